// File: rtl/lsi_state_machine.sv
// lsi_state_machine: top-level sequencing state register for the LSI datapath.
// Steps through the fixed processing sequence while run is high, holds while
// run is low, and can be force-loaded with any code through set/d.
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | sequence parked, waiting for run
// LOAD   | input load stage
// EMB    | embedding stage
// MIX1   | first mixing stage
// MIX2   | second mixing stage
// MIX3   | third mixing stage
// DENSE  | dense projection stage
// OUT    | output stage
// FINISH | last stage; the next advance wraps to IDLE
// 9..15  | undefined codes, reachable only by a load; advance goes to IDLE
module lsi_state_machine #(
    parameter int STATE_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 set,
    input  logic [STATE_LEN-1:0] d,
    output logic [STATE_LEN-1:0] q
);

    typedef enum logic [STATE_LEN-1:0] {
        IDLE   = 0,
        LOAD   = 1,
        EMB    = 2,
        MIX1   = 3,
        MIX2   = 4,
        MIX3   = 5,
        DENSE  = 6,
        OUT    = 7,
        FINISH = 8
    } state_t;

    state_t state_q;
    state_t state_d;

    // Next state: a load beats an advance; undefined codes recover to IDLE on advance.
    always_comb begin
        state_d = state_q;
        if (set) begin
            state_d = state_t'(d);
        end else if (run) begin
            case (state_q)
                IDLE:    state_d = LOAD;
                LOAD:    state_d = EMB;
                EMB:     state_d = MIX1;
                MIX1:    state_d = MIX2;
                MIX2:    state_d = MIX3;
                MIX3:    state_d = DENSE;
                DENSE:   state_d = OUT;
                OUT:     state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register; the reset input is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: tb/tb_lsi_state_machine.sv
// Testbench for lsi_state_machine: directed steps from the test plan followed
// by randomized stimulus checked against a behavioural model of the sequence.
module tb_lsi_state_machine;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       set;
    logic [3:0] d;
    logic [3:0] q;

    int         n_checks;
    int         n_fail;
    logic [3:0] mq;

    lsi_state_machine #(.STATE_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .set   (set),
        .d     (d),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence order as a plain lookup: codes 0..7 advance by one,
    // FINISH (8) and every undefined code return to IDLE.
    function automatic logic [3:0] seq_next(input logic [3:0] cur);
        int v;
        v = int'(cur);
        if (v < 8) return 4'(v + 1);
        return 4'd0;
    endfunction

    // Drive one cycle of inputs, take the edge, and advance the model.
    task automatic apply(input logic r, input logic ru, input logic s, input logic [3:0] dd);
        rst_n = r;
        run   = ru;
        set   = s;
        d     = dd;
        @(posedge clk);
        #1;
        if (r)       mq = 4'd0;
        else if (s)  mq = dd;
        else if (ru) mq = seq_next(mq);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: q=%0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        logic [3:0] free_exp [10];
        n_checks = 0;
        n_fail   = 0;
        mq       = 4'd0;
        rst_n    = 1'b0;
        run      = 1'b0;
        set      = 1'b0;
        d        = 4'd0;
        @(posedge clk);
        #1;

        // Reset overrides run and set.
        apply(1'b1, 1'b1, 1'b1, 4'd5);
        chk("reset", q, 4'd0);
        apply(1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset_release", q, 4'd0);

        // Free run through a full wrap.
        free_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd1};
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 4'd0);
            chk($sformatf("free_run_%0d", i), q, free_exp[i]);
        end

        // Hold and resume.
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("run_to_3", q, 4'd3);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 4'd0);
            chk($sformatf("hold_%0d", i), q, 4'd3);
        end
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("resume", q, 4'd4);

        // Load priority over run.
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("run_to_6", q, 4'd6);
        apply(1'b0, 1'b1, 1'b1, 4'd2);
        chk("load_beats_run", q, 4'd2);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, 4'd2);
            chk($sformatf("set_held_%0d", i), q, 4'd2);
        end
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("set_drop_advance", q, 4'd3);

        // Load with run low.
        apply(1'b0, 1'b0, 1'b1, 4'd0);
        chk("load_idle", q, 4'd0);
        apply(1'b0, 1'b0, 1'b0, 4'd9);
        chk("load_idle_hold", q, 4'd0);

        // Undefined code: holds with run low, recovers to IDLE on advance.
        apply(1'b0, 1'b0, 1'b1, 4'd12);
        chk("load_undef", q, 4'd12);
        apply(1'b0, 1'b0, 1'b0, 4'd0);
        chk("undef_hold_0", q, 4'd12);
        apply(1'b0, 1'b0, 1'b0, 4'd0);
        chk("undef_hold_1", q, 4'd12);
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("undef_recover", q, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("undef_then_load", q, 4'd1);

        // Tracking set: q follows d with one cycle of delay.
        apply(1'b0, 1'b1, 1'b1, 4'd15);
        chk("track_15", q, 4'd15);
        apply(1'b0, 1'b0, 1'b1, 4'd7);
        chk("track_7", q, 4'd7);

        // Reset mid-sequence during a load.
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        chk("to_finish", q, 4'd8);
        apply(1'b1, 1'b1, 1'b1, 4'd9);
        chk("reset_mid_set", q, 4'd0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            logic r, ru, s;
            logic [3:0] dd;
            r  = ($urandom_range(0, 24) == 0);
            s  = ($urandom_range(0, 5) == 0);
            ru = ($urandom_range(0, 3) != 0);
            dd = 4'($urandom_range(0, 15));
            apply(r, ru, s, dd);
            chk($sformatf("random_%0d", i), q, mq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
